// File: rtl/y_writeback_ctrl.sv
// Write-side sequencer for the layer output RAM: turns each accepted neuron
// result into one RAM write cycle and pulses layer_done when the layer is full.
module y_writeback_ctrl #(
  parameter int unsigned MAX_DEPTH   = 4,
  parameter int unsigned MAX_NEURONS = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LIDX_W      = 2,
  parameter int unsigned NIDX_W      = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [LIDX_W-1:0] start_layer,
  input  logic [NIDX_W:0]   start_count,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y_data,
  output logic              y_ready,
  output logic              ram_rw,
  output logic [LIDX_W-1:0] ram_layer_index,
  output logic [NIDX_W-1:0] ram_neuron_index,
  output logic [DATA_W-1:0] ram_y_in,
  output logic              busy,
  output logic              layer_done,
  output logic              err
);

  localparam int unsigned CNT_W = NIDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LIDX_W-1:0] layer_q;
  logic [CNT_W-1:0]  count_q;
  logic [NIDX_W-1:0] nidx_q;

  logic              start_ok_c;
  logic              accept_c;
  logic              last_c;

  logic              y_ready_nxt;
  logic              ram_rw_nxt;
  logic [LIDX_W-1:0] ram_layer_index_nxt;
  logic [NIDX_W-1:0] ram_neuron_index_nxt;
  logic [DATA_W-1:0] ram_y_in_nxt;
  logic              busy_nxt;
  logic              layer_done_nxt;
  logic              err_nxt;

  // Request qualification; layer 0 holds the master inputs and is never a target.
  always_comb begin
    start_ok_c = 1'b0;
    if (start && state == S_IDLE && start_layer != '0 && start_count != '0 &&
        32'(start_layer) <= (MAX_DEPTH - 1) && 32'(start_count) <= MAX_NEURONS) begin
      start_ok_c = 1'b1;
    end
  end

  assign accept_c = y_valid && (state == S_FILL);
  assign last_c   = accept_c && ({1'b0, nidx_q} == (count_q - CNT_W'(1)));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok_c) state_nxt = S_FILL;
      S_FILL:  if (last_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    y_ready_nxt          = (state_nxt == S_FILL);
    busy_nxt             = (state_nxt != S_IDLE);
    ram_rw_nxt           = accept_c;
    ram_layer_index_nxt  = ram_layer_index;
    ram_neuron_index_nxt = ram_neuron_index;
    ram_y_in_nxt         = ram_y_in;
    layer_done_nxt       = last_c;
    err_nxt              = start && !start_ok_c;
    if (accept_c) begin
      ram_layer_index_nxt  = layer_q;
      ram_neuron_index_nxt = nidx_q;
      ram_y_in_nxt         = y_data;
    end
  end

  // Output registers; the write lands exactly one cycle after the accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_ready          <= 1'b0;
      busy             <= 1'b0;
      ram_rw           <= 1'b0;
      ram_layer_index  <= '0;
      ram_neuron_index <= '0;
      ram_y_in         <= '0;
      layer_done       <= 1'b0;
      err              <= 1'b0;
    end else begin
      y_ready          <= y_ready_nxt;
      busy             <= busy_nxt;
      ram_rw           <= ram_rw_nxt;
      ram_layer_index  <= ram_layer_index_nxt;
      ram_neuron_index <= ram_neuron_index_nxt;
      ram_y_in         <= ram_y_in_nxt;
      layer_done       <= layer_done_nxt;
      err              <= err_nxt;
    end
  end

  // Fill context: target layer, beat count and running neuron index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      layer_q <= '0;
      count_q <= '0;
      nidx_q  <= '0;
    end else if (start_ok_c) begin
      layer_q <= start_layer;
      count_q <= start_count;
      nidx_q  <= '0;
    end else if (accept_c && !last_c) begin
      nidx_q  <= nidx_q + NIDX_W'(1);
    end
  end

endmodule

// File: tb/tb_y_writeback_ctrl.sv
// Scoreboard bench for y_writeback_ctrl: expected writes are queued as beats
// are driven and compared when the RAM strobe appears.
module tb_y_writeback_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [1:0]  start_layer;
  logic [3:0]  start_count;
  logic        y_valid;
  logic [15:0] y_data;
  logic        y_ready;
  logic        ram_rw;
  logic [1:0]  ram_layer_index;
  logic [2:0]  ram_neuron_index;
  logic [15:0] ram_y_in;
  logic        busy;
  logic        layer_done;
  logic        err;

  y_writeback_ctrl dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .start            (start),
    .start_layer      (start_layer),
    .start_count      (start_count),
    .y_valid          (y_valid),
    .y_data           (y_data),
    .y_ready          (y_ready),
    .ram_rw           (ram_rw),
    .ram_layer_index  (ram_layer_index),
    .ram_neuron_index (ram_neuron_index),
    .ram_y_in         (ram_y_in),
    .busy             (busy),
    .layer_done       (layer_done),
    .err              (err)
  );

  typedef struct packed {
    logic [1:0]  layer;
    logic [2:0]  nidx;
    logic [15:0] data;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_writes = 0;
  int          exp_dones = 0;
  int          writes_seen = 0;
  int          dones_seen = 0;
  int          remaining = 0;
  logic        in_done = 1'b0;
  logic [2:0]  cur_idx = '0;
  logic [1:0]  cur_layer = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // RAM-side monitor: every strobe must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (ram_rw) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(ram_rw), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_layer", 32'(ram_layer_index), 32'(e.layer));
          chk("wr_neuron", 32'(ram_neuron_index), 32'(e.nidx));
          chk("wr_data", 32'(ram_y_in), 32'(e.data));
          chk("wr_layer_done", 32'(layer_done), 32'(e.done));
          writes_seen++;
        end
      end else begin
        chk("layer_done_no_write", 32'(layer_done), 32'd0);
      end
      if (layer_done) dones_seen++;
    end
  end

  // One cycle of stimulus; entered and left 1 time unit after a rising edge.
  task automatic beat(input logic v, input logic [15:0] d, input logic st);
    logic nd;
    chk("y_ready", 32'(y_ready), 32'(remaining > 0));
    chk("busy", 32'(busy), 32'((remaining > 0) || in_done));
    y_valid     = v;
    y_data      = d;
    start       = st;
    start_layer = 2'd3;
    start_count = 4'd4;
    nd = 1'b0;
    if (v && remaining > 0) begin
      nd = (remaining == 1);
      exp_q.push_back('{layer: cur_layer, nidx: cur_idx, data: d, done: nd});
      exp_writes++;
      if (nd) exp_dones++;
      cur_idx = cur_idx + 3'd1;
      remaining--;
    end
    @(posedge CLK); #1;
    start   = 1'b0;
    in_done = nd;
    chk("err", 32'(err), 32'(st));
  endtask

  task automatic do_start(input logic [1:0] l, input logic [3:0] c);
    logic ok;
    chk("busy_before_start", 32'(busy), 32'd0);
    ok = (l != 2'd0) && (c >= 4'd1) && (c <= 4'd8);
    start       = 1'b1;
    start_layer = l;
    start_count = c;
    y_valid     = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("start_err", 32'(err), 32'(!ok));
    if (ok) begin
      remaining = int'(c);
      cur_idx   = '0;
      cur_layer = l;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_rw"}, 32'(ram_rw), 32'd0);
    chk({tag, "_y_ready"}, 32'(y_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_layer_done"}, 32'(layer_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_lidx"}, 32'(ram_layer_index), 32'd0);
    chk({tag, "_nidx"}, 32'(ram_neuron_index), 32'd0);
    chk({tag, "_y_in"}, 32'(ram_y_in), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; start = 1'b0; start_layer = '0; start_count = '0;
    y_valid = 1'b0; y_data = '0;
    #1;
    chk_all_zero("reset");
    #20;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    beat(1'b0, 16'h0, 1'b0);

    // Held-valid fill of three beats into layer 1.
    do_start(2'd1, 4'd3);
    beat(1'b1, 16'h0011, 1'b0);
    beat(1'b1, 16'h0022, 1'b0);
    beat(1'b1, 16'h0033, 1'b0);
    beat(1'b1, 16'h0044, 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    chk("q_empty_1", 32'(exp_q.size()), 32'd0);

    // Alternating valid into layer 2.
    do_start(2'd2, 4'd4);
    for (int i = 0; i < 8; i++) beat(i[0] == 1'b0, 16'h0200 + 16'(i), 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    chk("q_empty_2", 32'(exp_q.size()), 32'd0);

    // Rejected starts with valid data offered in idle.
    do_start(2'd0, 4'd2);
    beat(1'b1, 16'hdead, 1'b0);
    do_start(2'd1, 4'd0);
    beat(1'b1, 16'hbeef, 1'b0);
    do_start(2'd1, 4'd9);
    beat(1'b1, 16'hcafe, 1'b0);
    beat(1'b0, 16'h0, 1'b0);

    // Start during a full fill must be rejected without disturbing it.
    do_start(2'd2, 4'd8);
    for (int i = 0; i < 8; i++) beat(1'b1, 16'(($urandom & 32'hffff)), i == 3);
    beat(1'b1, 16'h1234, 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    chk("q_empty_4", 32'(exp_q.size()), 32'd0);

    // Reset mid-fill after two writes, then a single-beat fill.
    do_start(2'd1, 4'd5);
    beat(1'b1, 16'h0a01, 1'b0);
    beat(1'b1, 16'h0a02, 1'b0);
    y_valid = 1'b0;
    @(negedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    remaining = 0;
    in_done   = 1'b0;
    @(posedge CLK); #1;
    chk_all_zero("held_reset");
    RST_N = 1'b1;
    beat(1'b0, 16'h0, 1'b0);
    do_start(2'd3, 4'd1);
    beat(1'b1, 16'h0b0b, 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    chk("q_empty_5", 32'(exp_q.size()), 32'd0);

    // Top layer, full row, valid held past the end.
    do_start(2'd3, 4'd8);
    for (int i = 0; i < 11; i++) beat(1'b1, 16'h0c00 + 16'(i), 1'b0);
    beat(1'b0, 16'h0, 1'b0);
    chk("q_empty_6", 32'(exp_q.size()), 32'd0);

    chk("total_writes", 32'(writes_seen), 32'(exp_writes));
    chk("total_dones", 32'(dones_seen), 32'(exp_dones));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
